// File: rtl/troca_contexto.sv
// troca_contexto: context-switch engine that saves or restores the register
// file of one program (registers 1..31) to/from a per-program area in memory.
//
// A 16-bit time-slice counter runs in OCIOSO while preemption is enabled.
// When the slice expires, the engine stalls the CPU, writes r1..r31 of the
// current program to memory (SALVA), pulses desvioSO for one cycle (FIM) and
// releases the CPU. A one-cycle inicioRestaura request from the OS instead
// reads r1..r31 back from memory and writes them into the register file
// (LE/ESCREVE), with no desvioSO at the end.
//
// Parameters:
//   BASE_CONTEXTO  memory word address of the context save area
//   NUM_PROGS      number of program slots (power of two), 32 words per slot
// Ports:
//   clock, reset          clock (posedge) and asynchronous active-high reset
//   habilita, quantum     preemption enable and time slice (0 = no preemption)
//   progAtual             current program id (low log2(NUM_PROGS) bits used)
//   inicioRestaura        one-cycle OS request to restore progAtual's context
//   regLido               register-file read data for endReg
//   memLido, memPronto    memory read data and read/write acknowledge
//   pausaCPU              CPU stall
//   endReg, escreveReg, dadoReg   register-file address, write enable, data
//   endMem, escreveMem, leMem, dadoMem   memory address, strobes, write data
//   desvioSO              one-cycle pulse: divert the PC to the OS after a save
module troca_contexto #(
   parameter int BASE_CONTEXTO = 512,
   parameter int NUM_PROGS     = 8
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        habilita,
   input  logic [15:0] quantum,
   input  logic [31:0] progAtual,
   input  logic        inicioRestaura,
   input  logic [31:0] regLido,
   input  logic [31:0] memLido,
   input  logic        memPronto,
   output logic        pausaCPU,
   output logic [4:0]  endReg,
   output logic        escreveReg,
   output logic [31:0] dadoReg,
   output logic [31:0] endMem,
   output logic        escreveMem,
   output logic        leMem,
   output logic [31:0] dadoMem,
   output logic        desvioSO
);

   localparam int SW = (NUM_PROGS > 1) ? $clog2(NUM_PROGS) : 1;

   typedef enum logic [2:0] {
      OCIOSO,
      SALVA,
      LE,
      ESCREVE,
      FIM
   } estadoT;

   estadoT        estado;
   logic [15:0]   contador;
   logic [4:0]    r;
   logic [SW-1:0] slot;
   logic          contando;
   logic          unusedProgBits;

   // Only the low bits of the program id select a slot.
   assign unusedProgBits = ^progAtual[31:SW];

   assign contando = habilita && (quantum != 16'd0);

   // Address outputs are pure functions of the sampled slot and the register
   // index, so they stay stable while a memory access waits for memPronto.
   assign endMem  = 32'(BASE_CONTEXTO) + (32'(slot) << 5) + 32'(r);
   assign endReg  = r;
   assign dadoMem = regLido;

   // Single state machine. Strobes are registered and set on the transition
   // into the state that owns them, so each one is high exactly while its
   // state is active and all drop immediately on reset. The expiry test uses
   // >= so that shrinking quantum below the running count still preempts at
   // once instead of waiting for the counter to wrap.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         estado     <= OCIOSO;
         contador   <= 16'd0;
         r          <= 5'd1;
         slot       <= '0;
         dadoReg    <= 32'd0;
         pausaCPU   <= 1'b0;
         escreveMem <= 1'b0;
         leMem      <= 1'b0;
         escreveReg <= 1'b0;
         desvioSO   <= 1'b0;
      end else begin
         case (estado)
            OCIOSO: begin
               if (inicioRestaura) begin
                  contador <= 16'd0;
                  r        <= 5'd1;
                  slot     <= progAtual[SW-1:0];
                  estado   <= LE;
                  pausaCPU <= 1'b1;
                  leMem    <= 1'b1;
               end else if (contando) begin
                  if (contador >= quantum - 16'd1) begin
                     contador   <= 16'd0;
                     r          <= 5'd1;
                     slot       <= progAtual[SW-1:0];
                     estado     <= SALVA;
                     pausaCPU   <= 1'b1;
                     escreveMem <= 1'b1;
                  end else begin
                     contador <= contador + 16'd1;
                  end
               end
            end
            SALVA: begin
               if (memPronto) begin
                  if (r == 5'd31) begin
                     estado     <= FIM;
                     escreveMem <= 1'b0;
                     desvioSO   <= 1'b1;
                  end else begin
                     r <= r + 5'd1;
                  end
               end
            end
            FIM: begin
               estado   <= OCIOSO;
               desvioSO <= 1'b0;
               pausaCPU <= 1'b0;
               r        <= 5'd1;
            end
            LE: begin
               if (memPronto) begin
                  dadoReg    <= memLido;
                  estado     <= ESCREVE;
                  leMem      <= 1'b0;
                  escreveReg <= 1'b1;
               end
            end
            ESCREVE: begin
               escreveReg <= 1'b0;
               if (r == 5'd31) begin
                  estado   <= OCIOSO;
                  pausaCPU <= 1'b0;
                  r        <= 5'd1;
               end else begin
                  r      <= r + 5'd1;
                  estado <= LE;
                  leMem  <= 1'b1;
               end
            end
            default: begin
               estado     <= OCIOSO;
               pausaCPU   <= 1'b0;
               escreveMem <= 1'b0;
               leMem      <= 1'b0;
               escreveReg <= 1'b0;
               desvioSO   <= 1'b0;
               r          <= 5'd1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_troca_contexto.sv
// tb_troca_contexto: directed testbench for troca_contexto. Inputs change on
// the falling edge, outputs are sampled on the falling edge (or 1 ns after an
// asynchronous reset), and every expected value is hand-computed from the
// default parameters (BASE_CONTEXTO=512, 32 words per slot).
module tb_troca_contexto;

   logic        clock;
   logic        reset;
   logic        habilita;
   logic [15:0] quantum;
   logic [31:0] progAtual;
   logic        inicioRestaura;
   logic [31:0] regLido;
   logic [31:0] memLido;
   logic        memPronto;
   logic        pausaCPU;
   logic [4:0]  endReg;
   logic        escreveReg;
   logic [31:0] dadoReg;
   logic [31:0] endMem;
   logic        escreveMem;
   logic        leMem;
   logic [31:0] dadoMem;
   logic        desvioSO;

   int nChecks = 0;
   int nPass   = 0;

   troca_contexto #(.BASE_CONTEXTO(512), .NUM_PROGS(8)) dut (
      .clock(clock),
      .reset(reset),
      .habilita(habilita),
      .quantum(quantum),
      .progAtual(progAtual),
      .inicioRestaura(inicioRestaura),
      .regLido(regLido),
      .memLido(memLido),
      .memPronto(memPronto),
      .pausaCPU(pausaCPU),
      .endReg(endReg),
      .escreveReg(escreveReg),
      .dadoReg(dadoReg),
      .endMem(endMem),
      .escreveMem(escreveMem),
      .leMem(leMem),
      .dadoMem(dadoMem),
      .desvioSO(desvioSO)
   );

   // 10 ns clock
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      nChecks++;
      if (observed === expected) nPass++;
      else $display("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
   endtask

   // Drive the slow control inputs in one go.
   task automatic applyStimulus(input logic hab, input logic [15:0] q,
                                input logic [31:0] prog, input logic pronto);
      habilita  = hab;
      quantum   = q;
      progAtual = prog;
      memPronto = pronto;
   endtask

   // Hold reset for two cycles with preemption off, release on a falling edge.
   task automatic applyReset();
      @(negedge clock);
      reset = 1'b1;
      applyStimulus(1'b0, 16'd0, 32'd0, 1'b0);
      inicioRestaura = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   // Count falling edges until pausaCPU rises, bounded; a timeout returns the
   // bound, which no caller expects.
   task automatic waitPausa(output int cyc);
      cyc = 0;
      while (!pausaCPU && cyc < 200) begin
         @(negedge clock);
         cyc++;
      end
   endtask

   initial begin
      int cyc;
      int activity;
      int pausaCnt;
      int nEscReg;
      int nEscMem;
      int nDesvio;

      reset          = 1'b1;
      inicioRestaura = 1'b0;
      regLido        = 32'd0;
      memLido        = 32'd0;
      applyStimulus(1'b0, 16'd0, 32'd0, 1'b0);
      #1;

      // Reset state
      checkOutput("rstPausa", 32'(pausaCPU), 32'd0);
      checkOutput("rstEscMem", 32'(escreveMem), 32'd0);
      checkOutput("rstLeMem", 32'(leMem), 32'd0);
      checkOutput("rstEscReg", 32'(escreveReg), 32'd0);
      checkOutput("rstDesvio", 32'(desvioSO), 32'd0);
      checkOutput("rstDadoReg", dadoReg, 32'd0);
      checkOutput("rstEndReg", 32'(endReg), 32'd1);
      checkOutput("rstEndMem", endMem, 32'd513);
      repeat (2) @(negedge clock);
      reset = 1'b0;

      // Preemption disabled: quantum=0, then habilita=0, 1000 cycles each
      applyStimulus(1'b1, 16'd0, 32'd2, 1'b1);
      activity = 0;
      repeat (1000) begin
         @(negedge clock);
         if (pausaCPU || escreveMem || leMem || escreveReg || desvioSO) activity++;
      end
      checkOutput("idleQ0", 32'(activity), 32'd0);
      applyStimulus(1'b0, 16'd5, 32'd2, 1'b1);
      activity = 0;
      repeat (1000) begin
         @(negedge clock);
         if (pausaCPU || escreveMem || leMem || escreveReg || desvioSO) activity++;
      end
      checkOutput("idleHab0", 32'(activity), 32'd0);

      // Save of program 2 with quantum=5 and memPronto tied high; progAtual is
      // changed and a stray restore request arrives mid-save.
      applyStimulus(1'b1, 16'd5, 32'd2, 1'b1);
      waitPausa(cyc);
      checkOutput("saveLatency", 32'(cyc), 32'd5);
      pausaCnt = 0;
      for (int k = 1; k <= 31; k++) begin
         regLido = 32'hC0DE_0000 + 32'(k);
         #1;
         checkOutput("saveEscMem", 32'(escreveMem), 32'd1);
         checkOutput("saveEndMem", endMem, 32'(576 + k));
         checkOutput("saveEndReg", 32'(endReg), 32'(k));
         checkOutput("saveDadoMem", dadoMem, 32'hC0DE_0000 + 32'(k));
         checkOutput("saveStrobes", {29'd0, leMem, escreveReg, desvioSO}, 32'd0);
         if (pausaCPU) pausaCnt++;
         if (k == 10) begin
            progAtual      = 32'd6;
            inicioRestaura = 1'b1;
         end else begin
            inicioRestaura = 1'b0;
         end
         @(negedge clock);
      end
      inicioRestaura = 1'b0;
      habilita       = 1'b0;
      checkOutput("fimDesvio", 32'(desvioSO), 32'd1);
      checkOutput("fimEscMem", 32'(escreveMem), 32'd0);
      if (pausaCPU) pausaCnt++;
      @(negedge clock);
      checkOutput("postDesvio", 32'(desvioSO), 32'd0);
      checkOutput("postPausa", 32'(pausaCPU), 32'd0);
      checkOutput("savePausaCycles", 32'(pausaCnt), 32'd32);

      // Restore of program 3 with memPronto delayed two cycles per access
      applyStimulus(1'b0, 16'd5, 32'd3, 1'b0);
      inicioRestaura = 1'b1;
      @(negedge clock);
      inicioRestaura = 1'b0;
      for (int k = 1; k <= 31; k++) begin
         checkOutput("restLeMem", 32'(leMem), 32'd1);
         checkOutput("restEndMem", endMem, 32'(608 + k));
         @(negedge clock);
         checkOutput("restWait", 32'(leMem), 32'd1);
         memPronto = 1'b1;
         memLido   = 32'hBEEF_0000 + 32'(k * 3);
         @(negedge clock);
         memPronto = 1'b0;
         checkOutput("restEscReg", 32'(escreveReg), 32'd1);
         checkOutput("restDadoReg", dadoReg, 32'hBEEF_0000 + 32'(k * 3));
         checkOutput("restEndReg", 32'(endReg), 32'(k));
         checkOutput("restStrobes", {29'd0, leMem, escreveMem, desvioSO}, 32'd0);
         @(negedge clock);
      end
      checkOutput("restDonePausa", 32'(pausaCPU), 32'd0);
      checkOutput("restDoneEscReg", 32'(escreveReg), 32'd0);

      // Restore request on the very cycle the slice expires
      applyStimulus(1'b1, 16'd3, 32'd1, 1'b1);
      repeat (2) @(negedge clock);
      inicioRestaura = 1'b1;
      @(negedge clock);
      inicioRestaura = 1'b0;
      habilita       = 1'b0;
      checkOutput("raceLeMem", 32'(leMem), 32'd1);
      checkOutput("raceEndMem", endMem, 32'd545);
      nEscReg = 0;
      nEscMem = 0;
      nDesvio = 0;
      cyc     = 0;
      while (pausaCPU && cyc < 200) begin
         if (escreveReg) nEscReg++;
         if (escreveMem) nEscMem++;
         if (desvioSO) nDesvio++;
         @(negedge clock);
         cyc++;
      end
      checkOutput("raceEscRegCount", 32'(nEscReg), 32'd31);
      checkOutput("raceNoSave", 32'(nEscMem), 32'd0);
      checkOutput("raceNoDesvio", 32'(nDesvio), 32'd0);
      habilita = 1'b1;
      waitPausa(cyc);
      checkOutput("raceCounterCleared", 32'(cyc), 32'd3);

      // Reset in the middle of that save, at r=10
      repeat (9) @(negedge clock);
      checkOutput("midSaveEndReg", 32'(endReg), 32'd10);
      checkOutput("midSaveEscMem", 32'(escreveMem), 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("abortStrobes",
                  {27'd0, pausaCPU, escreveMem, leMem, escreveReg, desvioSO}, 32'd0);
      activity = 0;
      repeat (3) begin
         @(negedge clock);
         if (pausaCPU || escreveMem || leMem || escreveReg || desvioSO) activity++;
      end
      checkOutput("abortQuiet", 32'(activity), 32'd0);
      reset = 1'b0;
      waitPausa(cyc);
      checkOutput("postResetLatency", 32'(cyc), 32'd3);
      checkOutput("postResetEndReg", 32'(endReg), 32'd1);
      applyReset();

      // Pause semantics: habilita=0 holds the count instead of clearing it
      applyStimulus(1'b1, 16'd5, 32'd4, 1'b1);
      repeat (3) @(negedge clock);
      habilita = 1'b0;
      repeat (20) @(negedge clock);
      checkOutput("pauseNoPreempt", 32'(pausaCPU), 32'd0);
      habilita = 1'b1;
      waitPausa(cyc);
      checkOutput("pauseResume", 32'(cyc), 32'd2);
      checkOutput("pauseEndMem", endMem, 32'd641);
      applyReset();

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   // Global watchdog so the bench always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: observed timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/troca_contexto.md
TROCA_CONTEXTO -- requirements
Module: troca_contexto

Interface
REQ-001 SHALL have parameter BASE_CONTEXTO, default 512, meaning the memory word address of the context save area.
REQ-002 SHALL have parameter NUM_PROGS, default 8, meaning the number of program context slots (power of two).
REQ-003 SHALL have port clock, input, 1, the single clock; all state changes on posedge.
REQ-004 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-005 SHALL have port habilita, input, 1, meaning preemption enabled when high.
REQ-006 SHALL have port quantum, input, 16, meaning the time slice in cycles; 0 disables preemption.
REQ-007 SHALL have port progAtual, input, 32, meaning the current program id; only the low log2(NUM_PROGS) bits are used.
REQ-008 SHALL have port inicioRestaura, input, 1, meaning a one-cycle OS request to restore context of progAtual.
REQ-009 SHALL have port regLido, input, 32, meaning register-file read data for address endReg (combinational).
REQ-010 SHALL have port memLido, input, 32, meaning memory read data, valid when memPronto=1.
REQ-011 SHALL have port memPronto, input, 1, meaning memory acknowledges the current read/write.
REQ-012 SHALL have port pausaCPU, output, 1, meaning CPU stall while high.
REQ-013 SHALL have port endReg, output, 5, meaning the register-file address (read or write).
REQ-014 SHALL have port escreveReg, output, 1, meaning the register-file write enable.
REQ-015 SHALL have port dadoReg, output, 32, meaning the register-file write data.
REQ-016 SHALL have port endMem, output, 32, meaning the memory word address.
REQ-017 SHALL have ports escreveMem and leMem, output, 1 each, meaning memory write and read requests.
REQ-018 SHALL have port dadoMem, output, 32, equal to regLido.
REQ-019 SHALL have port desvioSO, output, 1, meaning a one-cycle pulse to divert the PC to the OS after a save.

Function
REQ-020 SHALL implement states OCIOSO, SALVA, LE, ESCREVE and FIM.
REQ-021 In OCIOSO, the 16-bit counter SHALL increment each cycle while habilita=1 and quantum!=0, and SHALL hold otherwise.
REQ-022 When the counter equals quantum-1 in OCIOSO, the counter SHALL clear and the state SHALL go to SALVA next cycle, with r=1 and slot=progAtual sampled.
REQ-023 inicioRestaura in OCIOSO SHALL clear the counter and go to LE with r=1 and slot sampled; it SHALL win over a same-cycle quantum expiry, which is then discarded.
REQ-024 inicioRestaura outside OCIOSO SHALL be ignored.
REQ-025 endMem SHALL equal BASE_CONTEXTO + slot*32 + r (32-bit unsigned); endReg SHALL equal r in SALVA, LE and ESCREVE.
REQ-026 In SALVA, escreveMem SHALL be 1 and held with a stable address until memPronto=1; on acceptance, r increments, or on r=31 the state goes to FIM.
REQ-027 FIM SHALL last one cycle with desvioSO=1, then go to OCIOSO.
REQ-028 In LE, leMem SHALL be 1 until memPronto=1; memLido is then captured into dadoReg and the state goes to ESCREVE.
REQ-029 ESCREVE SHALL last one cycle with escreveReg=1; then r increments and the state returns to LE, or on r=31 goes to OCIOSO with no desvioSO.
REQ-030 Register 0 SHALL never be saved or restored; exactly 31 transfers SHALL occur per operation.
REQ-031 pausaCPU SHALL be 1 in every state except OCIOSO; escreveMem, leMem and escreveReg SHALL never be high simultaneously.
REQ-032 Changes to habilita, quantum or progAtual during SALVA, LE or ESCREVE SHALL NOT affect the operation in progress.
REQ-033 In OCIOSO, the counter SHALL NOT be cleared by habilita=0 (pause semantics).

Reset
REQ-034 reset SHALL immediately force state OCIOSO, counter=0, r=1, slot=0, dadoReg=0, and all output strobes (pausaCPU, escreveMem, leMem, escreveReg, desvioSO) to 0.
REQ-035 reset mid-save or mid-restore SHALL abort with no further memory or register writes and no desvioSO.

Verification
REQ-036 quantum=5, habilita=1, memPronto tied 1 -> SALVA entered after 5 counted cycles; 31 writes to 512+prog*32+1..+31; desvioSO pulses once; pausaCPU high for 32 cycles.
REQ-037 progAtual=3, inicioRestaura pulse, memPronto delayed 2 cycles per access -> 31 escreveReg pulses, endMem 609..639, dadoReg=memLido, no desvioSO.
REQ-038 inicioRestaura on the same cycle as quantum expiry -> restore only, counter=0, no save writes.
REQ-039 quantum=0 or habilita=0 for 1000 cycles -> pausaCPU stays 0, no memory activity; counter held when habilita toggles.
REQ-040 reset asserted at save r=10 -> outputs 0 within the same cycle; after release, OCIOSO with counter=0.
REQ-041 progAtual changed during a save -> all addresses keep the originally sampled slot.
